// File: rtl/maxfinder_pkg.sv
// Shared types and helpers for the maxfinder controller slice.
// Scan states, default widths and the range-length calculation.
package maxfinder_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } state_t;

   // Number of entries in an inclusive, wrapping address range: 1..2^aw.
   function automatic int unsigned scan_len(input int unsigned first,
                                            input int unsigned last,
                                            input int unsigned aw);
      return ((last - first) & ((32'd1 << aw) - 32'd1)) + 32'd1;
   endfunction

endpackage

// File: rtl/maxfinder_track.sv
// Running-extremum register: keeps the best value seen and its address.
// GREATER=1 tracks the maximum, GREATER=0 the minimum; ties keep the older entry.
module maxfinder_track
   import maxfinder_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter bit GREATER = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          load,
   input  logic [DW-1:0] data,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] best_val,
   output logic [AW-1:0] best_addr
);

   logic better;

   always_comb begin
      better = GREATER ? (data > best_val) : (data < best_val);
   end

   // The first sample of a scan loads unconditionally; later ones must strictly win.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         best_val  <= '0;
         best_addr <= '0;
      end else if (en && (load || better)) begin
         best_val  <= data;
         best_addr <= addr;
      end
   end

endmodule

// File: rtl/maxfinder_ctrl.sv
// Scans a wrapping address range of a synchronous-read ROM and reports the extremum.
// Define MIN_TRACK_EN to add min_val/min_addr alongside the maximum.
module maxfinder_ctrl
   import maxfinder_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] first_addr,
   input  logic [AW-1:0] last_addr,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_dout,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] max_val,
`ifdef MIN_TRACK_EN
   output logic [AW-1:0] max_addr,
   output logic [DW-1:0] min_val,
   output logic [AW-1:0] min_addr
`else
   output logic [AW-1:0] max_addr
`endif
);

   state_t        state, state_nx;
   logic [AW-1:0] remaining, remaining_nx;
   logic [AW-1:0] rom_addr_nx;
   logic [AW-1:0] addr_d, addr_d_nx;
   logic          valid_d, valid_nx;
   logic          first_pend, first_pend_nx;
   logic          busy_nx, done_nx;

   // A start seen while done is still high belongs to the finishing scan and is dropped.
   always_comb begin
      state_nx      = state;
      remaining_nx  = remaining;
      rom_addr_nx   = rom_addr;
      addr_d_nx     = addr_d;
      valid_nx      = 1'b0;
      first_pend_nx = first_pend;
      busy_nx       = busy;
      done_nx       = 1'b0;

      if (valid_d) begin
         first_pend_nx = 1'b0;
      end

      case (state)
         IDLE: begin
            if (start && !done) begin
               rom_addr_nx   = first_addr;
               remaining_nx  = AW'(scan_len(32'(first_addr), 32'(last_addr), AW) - 32'd1);
               busy_nx       = 1'b1;
               first_pend_nx = 1'b1;
               state_nx      = SCAN;
            end
         end
         SCAN: begin
            valid_nx  = 1'b1;
            addr_d_nx = rom_addr;
            if (remaining == '0) begin
               state_nx = DRAIN;
            end else begin
               rom_addr_nx  = rom_addr + AW'(1);
               remaining_nx = remaining - AW'(1);
            end
         end
         DRAIN: begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         remaining  <= '0;
         rom_addr   <= '0;
         addr_d     <= '0;
         valid_d    <= 1'b0;
         first_pend <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         remaining  <= remaining_nx;
         rom_addr   <= rom_addr_nx;
         addr_d     <= addr_d_nx;
         valid_d    <= valid_nx;
         first_pend <= first_pend_nx;
         busy       <= busy_nx;
         done       <= done_nx;
      end
   end

   maxfinder_track #(.AW(AW), .DW(DW), .GREATER(1'b1)) u_max (
      .clk       (clk),
      .reset     (reset),
      .en        (valid_d),
      .load      (first_pend),
      .data      (rom_dout),
      .addr      (addr_d),
      .best_val  (max_val),
      .best_addr (max_addr)
   );

`ifdef MIN_TRACK_EN
   maxfinder_track #(.AW(AW), .DW(DW), .GREATER(1'b0)) u_min (
      .clk       (clk),
      .reset     (reset),
      .en        (valid_d),
      .load      (first_pend),
      .data      (rom_dout),
      .addr      (addr_d),
      .best_val  (min_val),
      .best_addr (min_addr)
   );
`else
`endif

endmodule

// File: tb/tb_maxfinder_ctrl.sv
// Self-checking bench for maxfinder_ctrl with a behavioural ROM and scan model.
// Define MIN_TRACK_EN to also check the minimum outputs.
module tb_maxfinder_ctrl;

   localparam int AW = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_dout;
   logic          busy;
   logic          done;
   logic [DW-1:0] max_val;
   logic [AW-1:0] max_addr;
`ifdef MIN_TRACK_EN
   logic [DW-1:0] min_val;
   logic [AW-1:0] min_addr;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] rom_mem  [16];
   logic [DW-1:0] plan_rom [16] = '{4'd0, 4'd1, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0,
                                    4'd0, 4'd5, 4'd0, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0};

   typedef struct {
      string name;
      int    first;
      int    last;
      int    mx;
      int    mxa;
      int    mn;
      int    mna;
      int    edges;
   } vec_t;

   vec_t vecs [6];

   maxfinder_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .rom_addr   (rom_addr),
      .rom_dout   (rom_dout),
      .busy       (busy),
      .done       (done),
      .max_val    (max_val),
`ifdef MIN_TRACK_EN
      .max_addr   (max_addr),
      .min_val    (min_val),
      .min_addr   (min_addr)
`else
      .max_addr   (max_addr)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read ROM: data for the address seen at an edge appears after that edge.
   always @(posedge clk) rom_dout <= rom_mem[rom_addr];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference: walk the range in scan order, keeping the earliest strict extremum.
   task automatic refScan(input int first, input int last,
                          output int n, output int mx, output int mxa, output int mn, output int mna);
      n = ((last - first) & 15) + 1;
      mx = 0; mxa = 0; mn = 0; mna = 0;
      for (int i = 0; i < n; i++) begin
         int a;
         a = (first + i) & 15;
         if (i == 0 || int'(rom_mem[a]) > mx) begin mx = int'(rom_mem[a]); mxa = a; end
         if (i == 0 || int'(rom_mem[a]) < mn) begin mn = int'(rom_mem[a]); mna = a; end
      end
   endtask

   // Presents a start request and returns just after the accept edge.
   task automatic applyStimulus(input int first, input int last);
      @(negedge clk);
      first_addr = AW'(first);
      last_addr  = AW'(last);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Follows a scan edge by edge until done; optionally pulses start at edge pulse_at.
   task automatic waitDone(input int first, input int n, input int pulse_at,
                           output int edges, output int busy_cycles, output int addr_errs);
      edges       = 0;
      busy_cycles = busy ? 1 : 0;
      addr_errs   = (rom_addr == AW'(first)) ? 0 : 1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (pulse_at != 0 && e == pulse_at) begin
            start      = 1'b1;
            first_addr = AW'(9);
            last_addr  = AW'(9);
         end
         if (pulse_at != 0 && e == pulse_at + 1) start = 1'b0;
         if (done) begin
            edges = e;
            break;
         end
         if (busy) busy_cycles++;
         if (e <= n && rom_addr != AW'((first + ((e < n - 1) ? e : n - 1)) & 15)) addr_errs++;
      end
   endtask

   task automatic checkResult(input string name, input int mx, input int mxa, input int mn, input int mna);
      checkOutput({name, "_max_val"}, 32'(max_val), mx);
      checkOutput({name, "_max_addr"}, 32'(max_addr), mxa);
`ifdef MIN_TRACK_EN
      checkOutput({name, "_min_val"}, 32'(min_val), mn);
      checkOutput({name, "_min_addr"}, 32'(min_addr), mna);
`else
      if (mn < 0 || mna < 0) $display("[TB] unexpected negative reference");
`endif
   endtask

   task automatic runCase(input string name, input int first, input int last,
                          input int mx, input int mxa, input int mn, input int mna, input int exp_edges);
      int edges, busy_cycles, addr_errs;
      applyStimulus(first, last);
      waitDone(first, exp_edges - 1, 0, edges, busy_cycles, addr_errs);
      checkOutput({name, "_done_edges"}, edges, exp_edges);
      checkOutput({name, "_busy_cycles"}, busy_cycles, exp_edges);
      checkOutput({name, "_rom_addr_seq_errs"}, addr_errs, 0);
      checkResult(name, mx, mxa, mn, mna);
      @(posedge clk);
      #1;
      checkOutput({name, "_done_one_cycle"}, 32'(done), 0);
      checkResult({name, "_hold"}, mx, mxa, mn, mna);
   endtask

   initial begin
      int edges, busy_cycles, addr_errs, done_seen;
      int n, mx, mxa, mn, mna;

      vecs[0] = '{"full",    0, 15, 10, 12, 0, 0,  17};
      vecs[1] = '{"partial", 0, 11,  7,  3, 0, 0,  13};
      vecs[2] = '{"single",  9,  9,  5,  9, 5, 9,   2};
      vecs[3] = '{"wrap",   13,  3,  7,  3, 0, 13,  8};
      vecs[4] = '{"allzero", 4,  8,  0,  4, 0, 4,   6};
      vecs[5] = '{"tiewrap", 5,  2, 10, 12, 0, 5,  15};

      foreach (rom_mem[i]) rom_mem[i] = plan_rom[i];
      reset = 1'b1;
      start = 1'b0;
      first_addr = '0;
      last_addr  = '0;
      #12;
      checkOutput("reset_rom_addr", 32'(rom_addr), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_done", 32'(done), 0);
      checkOutput("reset_max_val", 32'(max_val), 0);
      checkOutput("reset_max_addr", 32'(max_addr), 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         runCase(vecs[i].name, vecs[i].first, vecs[i].last, vecs[i].mx, vecs[i].mxa,
                 vecs[i].mn, vecs[i].mna, vecs[i].edges);
      end

      // Start pulsed mid-scan and during the done cycle is dropped; the cycle after is taken.
      applyStimulus(0, 15);
      waitDone(0, 16, 4, edges, busy_cycles, addr_errs);
      checkOutput("hs_done_edges", edges, 17);
      checkOutput("hs_rom_addr_seq_errs", addr_errs, 0);
      checkResult("hs_first", 10, 12, 0, 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("hs_start_in_done_busy", 32'(busy), 0);
      checkOutput("hs_second_done", 32'(done), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("hs_start_after_done_busy", 32'(busy), 1);
      waitDone(9, 1, 0, edges, busy_cycles, addr_errs);
      checkOutput("hs_rescan_edges", edges, 2);
      checkResult("hs_rescan", 5, 9, 5, 9);

      // Asynchronous reset in the middle of a full scan.
      applyStimulus(0, 15);
      repeat (6) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("arst_rom_addr", 32'(rom_addr), 0);
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_done", 32'(done), 0);
      checkOutput("arst_max_val", 32'(max_val), 0);
      checkOutput("arst_max_addr", 32'(max_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done || busy) done_seen++;
      end
      checkOutput("arst_no_done", done_seen, 0);
      runCase("post_reset", 0, 15, 10, 12, 0, 0, 17);

      // Random ROM contents and ranges against the reference model.
      for (int t = 0; t < 16; t++) begin
         int f, l;
         foreach (rom_mem[i]) rom_mem[i] = DW'($urandom_range(0, 15));
         f = int'($urandom_range(0, 15));
         l = int'($urandom_range(0, 15));
         refScan(f, l, n, mx, mxa, mn, mna);
         runCase($sformatf("rand%0d", t), f, l, mx, mxa, mn, mna, n + 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
